// File: rtl/filt_stim_if.sv
// Stimulus-generator control/sample bundle.
// Control inputs (start, stop, mode, num_samples, phase_inc) run from the
// controller to the generator. Outputs (x_out, x_valid, busy, done) run
// from the generator to the filter and the controller.
//   master : the controller side (drives control, observes samples/status)
//   slave  : the generator side (filt_stim_gen)
interface filt_stim_if #(
  parameter int DW      = 18,
  parameter int PHASE_W = 16
);
  logic                 start;
  logic                 stop;
  logic [2:0]           mode;
  logic [15:0]          num_samples;
  logic [PHASE_W-1:0]   phase_inc;
  logic signed [DW-1:0] x_out;
  logic                 x_valid;
  logic                 busy;
  logic                 done;

  modport master (
    output start, stop, mode, num_samples, phase_inc,
    input  x_out, x_valid, busy, done
  );

  modport slave (
    input  start, stop, mode, num_samples, phase_inc,
    output x_out, x_valid, busy, done
  );
endinterface

// File: rtl/filt_stim_gen.sv
// filt_stim_gen
// Synthesizable stimulus source for sine_filt. Emits one signed 1s(DW-1)
// sample per clk while x_valid is high: zero, impulse, step, worst-case,
// quarter-wave-LUT sine or PRBS sequences.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high
//   bus    filt_stim_if.slave: start/stop/mode/num_samples/phase_inc in,
//          x_out/x_valid/busy/done out
// Every mode passes through the same two-stage pipeline: stage 1 registers
// a compact sample descriptor (source, sign, LUT address), stage 2 turns it
// into the signed output word.
module filt_stim_gen #(
  parameter int              DW       = 18,
  parameter int              PHASE_W  = 16,
  parameter int              LUT_AW   = 6,
  parameter int              N_TAPS   = 16,
  parameter logic [N_TAPS-1:0] WC_SIGNS = '0,
  parameter int              IMP_PER  = 64
) (
  input  logic       clk,
  input  logic       reset,
  filt_stim_if.slave bus
);

  localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int IMP_W = $clog2(IMP_PER);
  localparam int LUT_N = 2 ** LUT_AW;
  localparam logic [DW-2:0] MAG_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef enum logic [2:0] {
    M_ZERO  = 3'd0,
    M_IMP   = 3'd1,
    M_STEP  = 3'd2,
    M_WORST = 3'd3,
    M_SINE  = 3'd4,
    M_PRBS  = 3'd5
  } mode_t;

  typedef enum logic [1:0] {SRC_ZERO, SRC_MAX, SRC_LUT} src_t;

  typedef struct packed {
    logic              valid;
    src_t              src;
    logic              neg;
    logic [LUT_AW-1:0] addr;
  } stage_t;

  // Quarter-wave table, half-step offset so the reconstructed wave is
  // odd-symmetric and never needs the most negative code.
  function automatic logic [DW-2:0] lut_entry(input int k);
    real ang;
    real val;
    ang = 3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(LUT_N);
    val = real'(2 ** (DW - 1) - 1) * $sin(ang);
    return (DW-1)'($rtoi(val + 0.5));
  endfunction

  logic [DW-2:0] lut [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign lut[k] = lut_entry(k);
  end

  state_t               state_q, state_d;
  logic                 drain_q;
  logic                 done_q;
  mode_t                mode_q;
  logic [15:0]          num_q;
  logic [PHASE_W-1:0]   inc_q;
  logic [15:0]          sample_cnt;
  logic [TAP_W-1:0]     tap_cnt;
  logic [IMP_W-1:0]     imp_cnt;
  logic [PHASE_W-1:0]   phase_q;
  logic [16:0]          lfsr_q;
  stage_t               s0, s1_q;

  logic                 accept;
  logic                 issue;
  logic                 last;
  logic [1:0]           quad;
  logic [LUT_AW-1:0]    addr_raw;
  logic [TAP_W-1:0]     wc_idx;
  logic [DW-2:0]        mag;
  logic signed [DW-1:0] pos;
  logic signed [DW-1:0] x_d;

  // In continuous mode (num_q == 0) the run never ends on count.
  assign last     = (num_q != 16'd0) && (sample_cnt == num_q - 16'd1);
  assign quad     = phase_q[PHASE_W-1 -: 2];
  assign addr_raw = phase_q[PHASE_W-3 -: LUT_AW];
  // Sample n uses h[N_TAPS-1-n] so every product shares a sign at the peak.
  assign wc_idx   = TAP_W'(N_TAPS - 1) - tap_cnt;

  // done is registered one cycle into IDLE, so busy must also cover it;
  // a start in that cycle is ignored for the same reason.
  assign bus.busy = (state_q != S_IDLE) || done_q;
  assign bus.done = done_q;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !done_q) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_DRAIN;
        end else begin
          issue = 1'b1;
          if (last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 0: describe the sample to issue this cycle.
  always_comb begin
    s0       = '0;
    s0.valid = issue;
    case (mode_q)
      M_IMP:   s0.src = (imp_cnt == '0) ? SRC_MAX : SRC_ZERO;
      M_STEP:  s0.src = SRC_MAX;
      M_WORST: begin
        s0.src = SRC_MAX;
        s0.neg = WC_SIGNS[wc_idx];
      end
      M_SINE: begin
        s0.src  = SRC_LUT;
        // Odd quadrants read the table backwards, lower half is negated.
        s0.addr = quad[0] ? ~addr_raw : addr_raw;
        s0.neg  = quad[1];
      end
      M_PRBS: begin
        s0.src = SRC_MAX;
        s0.neg = lfsr_q[0];
      end
      default: s0.src = SRC_ZERO;
    endcase
  end

  // Stage 2 value: magnitude is at most MAX, so negation never yields
  // the most negative code.
  always_comb begin
    mag = '0;
    case (s1_q.src)
      SRC_MAX: mag = MAG_MAX;
      SRC_LUT: mag = lut[s1_q.addr];
      default: mag = '0;
    endcase
    pos = {1'b0, mag};
    x_d = s1_q.neg ? -pos : pos;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drain_q     <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= M_ZERO;
      num_q       <= '0;
      inc_q       <= '0;
      sample_cnt  <= '0;
      tap_cnt     <= '0;
      imp_cnt     <= '0;
      phase_q     <= '0;
      lfsr_q      <= 17'h00001;
      s1_q        <= '0;
      bus.x_out   <= '0;
      bus.x_valid <= 1'b0;
    end else begin
      if (accept) begin
        mode_q     <= mode_t'(bus.mode);
        num_q      <= bus.num_samples;
        inc_q      <= bus.phase_inc;
        sample_cnt <= '0;
        tap_cnt    <= '0;
        imp_cnt    <= '0;
        phase_q    <= '0;
        lfsr_q     <= 17'h00001;
      end else if (issue) begin
        if (sample_cnt != 16'hFFFF) sample_cnt <= sample_cnt + 16'd1;
        tap_cnt <= (tap_cnt == TAP_W'(N_TAPS - 1)) ? '0 : tap_cnt + 1'b1;
        imp_cnt <= (imp_cnt == IMP_W'(IMP_PER - 1)) ? '0 : imp_cnt + 1'b1;
        phase_q <= phase_q + inc_q;
        // Fibonacci x^17 + x^14 + 1, one step per issued sample.
        lfsr_q  <= {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]};
      end

      s1_q        <= s0;
      bus.x_valid <= s1_q.valid;
      bus.x_out   <= s1_q.valid ? x_d : '0;

      // DRAIN lasts two cycles; done fires once, when the pipeline has no
      // sample left in stage 1 (covers both natural end and stop).
      drain_q <= (state_q == S_DRAIN);
      done_q  <= (state_q == S_DRAIN) && !s1_q.valid && !done_q;
    end
  end

endmodule
